// File: rtl/dtcm_mp_arb.sv
// dtcm_mp_arb: single-port data TCM shared by NUM_PORTS requestors through a per-cycle arbiter
module dtcm_mp_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 8192,
   parameter int NUM_PORTS  = 3,
   parameter int ARB_MODE   = 0
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [NUM_PORTS-1:0]              req_valid,
   output logic [NUM_PORTS-1:0]              req_ready,
   input  logic [NUM_PORTS-1:0]              req_wr,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_strb,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_PORTS-1:0]              rsp_valid,
   output logic                              rsp_err,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic                              wr_err
);
   localparam int SB  = DATA_WIDTH / 8;
   localparam int OFF = $clog2(SB);
   localparam int IW  = $clog2(DEPTH);
   localparam int PW  = $clog2(NUM_PORTS);

   if (DATA_WIDTH % 8 != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_param
      $error("dtcm_mp_arb: illegal DATA_WIDTH, DEPTH or NUM_PORTS");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         ptr, win;
   logic                  found, wr_s, in_rng;
   logic [SB-1:0]         strb_s;
   logic [ADDR_WIDTH-1:0] addr_s, widx;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic [IW-1:0]         ridx;

   // i-th candidate in search order: plain index or rotated from the round-robin pointer
   function automatic logic [PW-1:0] port_at(input logic [PW-1:0] p, input int i);
      return PW'((ARB_MODE != 0) ? (int'(p) + i) % NUM_PORTS : i);
   endfunction

   // pick the first valid port in search order
   always_comb begin
      win = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req_valid[port_at(ptr, i)]) begin
            found = 1'b1;
            win = port_at(ptr, i);
         end
      end
   end

   assign req_ready = found ? NUM_PORTS'(1) << win : '0;
   assign wr_s      = req_wr[win];
   assign strb_s    = req_strb[int'(win)*SB +: SB];
   assign addr_s    = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
   assign wdata_s   = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
   assign widx      = addr_s >> OFF;
   assign in_rng    = (widx >> IW) == '0;
   assign ridx      = widx[IW-1:0];

   // RAM write port, byte lanes gated by the winner's strobes
   always_ff @(posedge clk) begin
      if (found && wr_s && in_rng)
         for (int b = 0; b < SB; b++)
            if (strb_s[b]) mem[ridx][b*8 +: 8] <= wdata_s[b*8 +: 8];
   end

   // read response, error flags and round-robin pointer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         wr_err    <= 1'b0;
         ptr       <= '0;
      end else begin
         rsp_valid <= (found && !wr_s) ? req_ready : '0;
         rsp_err   <= found && !wr_s && !in_rng;
         wr_err    <= found && wr_s && !in_rng;
         if (found && !wr_s) rsp_rdata <= in_rng ? mem[ridx] : '0;
         if (found) ptr <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
      end
   end
endmodule

// File: tb/tb_dtcm_mp_arb.sv
// tb_dtcm_mp_arb: fixed-priority and round-robin instances checked against a word-level reference model
module tb_dtcm_mp_arb;
   logic        clk = 1'b0, rstn = 1'b0;
   logic [2:0]  rv [2], rw [2], rdy [2], rspv [2];
   logic [11:0] rs [2];
   logic [95:0] ra [2], rd [2];
   logic        rerr [2], werr [2];
   logic [31:0] rdat [2];

   logic [31:0] mdl [2][64];
   int          ptr_m [2], gw [2];
   logic [2:0]  e_v [2];
   logic        e_err [2], e_werr [2];
   logic [31:0] e_dat [2];
   int          n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   dtcm_mp_arb #(.ARB_MODE(0)) u_fix (
      .clk(clk), .rstn(rstn), .req_valid(rv[0]), .req_ready(rdy[0]), .req_wr(rw[0]),
      .req_strb(rs[0]), .req_addr(ra[0]), .req_wdata(rd[0]), .rsp_valid(rspv[0]),
      .rsp_err(rerr[0]), .rsp_rdata(rdat[0]), .wr_err(werr[0]));

   dtcm_mp_arb #(.ARB_MODE(1)) u_rr (
      .clk(clk), .rstn(rstn), .req_valid(rv[1]), .req_ready(rdy[1]), .req_wr(rw[1]),
      .req_strb(rs[1]), .req_addr(ra[1]), .req_wdata(rd[1]), .rsp_valid(rspv[1]),
      .rsp_err(rerr[1]), .rsp_rdata(rdat[1]), .wr_err(werr[1]));

   function automatic int winner(int m);
      int p;
      for (int i = 0; i < 3; i++) begin
         p = (m == 1) ? (ptr_m[m] + i) % 3 : i;
         if (rv[m][p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [2:0] onehot(int w);
      return (w < 0) ? 3'b000 : 3'(1 << w);
   endfunction

   task automatic req(int m, int p, logic wr, logic [3:0] s, logic [31:0] a, logic [31:0] d);
      rv[m][p] = 1'b1;
      rw[m][p] = wr;
      rs[m][p*4 +: 4] = s;
      ra[m][p*32 +: 32] = a;
      rd[m][p*32 +: 32] = d;
   endtask

   task automatic clr(int m);
      rv[m] = '0; rw[m] = '0; rs[m] = '0; ra[m] = '0; rd[m] = '0;
   endtask

   task automatic model_reset;
      for (int m = 0; m < 2; m++) begin
         ptr_m[m] = 0; gw[m] = -1; e_v[m] = '0; e_err[m] = 0; e_werr[m] = 0; e_dat[m] = '0;
      end
   endtask

   // advance one clock edge, updating the model with whatever each instance should grant
   task automatic tick;
      int w, idx;
      logic [31:0] a;
      logic oor;
      for (int m = 0; m < 2; m++) begin
         w = winner(m);
         gw[m] = w;
         e_v[m] = '0; e_err[m] = 0; e_werr[m] = 0;
         if (w >= 0) begin
            a = ra[m][w*32 +: 32];
            oor = (a >> 2) >= 8192;
            idx = int'((a >> 2) & 63);
            if (rw[m][w]) begin
               e_werr[m] = oor;
               if (!oor)
                  for (int b = 0; b < 4; b++)
                     if (rs[m][w*4+b]) mdl[m][idx][b*8 +: 8] = rd[m][w*32+b*8 +: 8];
            end else begin
               e_v[m] = onehot(w);
               e_err[m] = oor;
               e_dat[m] = oor ? 32'h0 : mdl[m][idx];
            end
            if (m == 1) ptr_m[m] = (w + 1) % 3;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int m = 0; m < 2; m++) begin
         n_chk += 5;
         if (rspv[m] !== 3'b000) begin n_err++; $display("FAIL reset_rsp_valid m%0d: got %b want 000", m, rspv[m]); end
         if (rerr[m] !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err m%0d: got %b want 0", m, rerr[m]); end
         if (werr[m] !== 1'b0) begin n_err++; $display("FAIL reset_wr_err m%0d: got %b want 0", m, werr[m]); end
         if (rdat[m] !== 32'h0) begin n_err++; $display("FAIL reset_rdata m%0d: got %h want 0", m, rdat[m]); end
         if (rdy[m] !== 3'b000) begin n_err++; $display("FAIL reset_ready m%0d: got %b want 000", m, rdy[m]); end
      end
   endtask

   task automatic init_mem;
      for (int w = 0; w < 64; w++) begin
         for (int m = 0; m < 2; m++) begin
            clr(m);
            req(m, 0, 1'b1, 4'hF, 32'(w * 4), $urandom);
         end
         tick;
      end
      clr(0); clr(1);
   endtask

   task automatic test_basic;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); end
      tick;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 1, 1'b0, 4'h0, 32'h10, 32'h0); end
      #1;
      for (int m = 0; m < 2; m++) begin
         n_chk++;
         if (rdy[m] !== 3'b010) begin n_err++; $display("FAIL basic_ready m%0d: got %b want 010", m, rdy[m]); end
      end
      tick;
      for (int m = 0; m < 2; m++) begin
         clr(m);
         n_chk += 3;
         if (rspv[m] !== 3'b010) begin n_err++; $display("FAIL basic_rsp_valid m%0d: got %b want 010", m, rspv[m]); end
         if (rdat[m] !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rdata m%0d: got %h want deadbeef", m, rdat[m]); end
         if (rerr[m] !== 1'b0) begin n_err++; $display("FAIL basic_rsp_err m%0d: got %b want 0", m, rerr[m]); end
      end
   endtask

   task automatic test_strobes;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 2, 1'b1, 4'hF, 32'h20, 32'h11223344); end
      tick;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 2, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD); end
      tick;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 2, 1'b0, 4'h0, 32'h22, 32'h0); end
      tick;
      for (int m = 0; m < 2; m++) begin
         clr(m);
         n_chk += 2;
         if (rspv[m] !== 3'b100) begin n_err++; $display("FAIL strb_rsp_valid m%0d: got %b want 100", m, rspv[m]); end
         if (rdat[m] !== 32'h11BB33DD) begin n_err++; $display("FAIL strb_rdata m%0d: got %h want 11bb33dd", m, rdat[m]); end
      end
   endtask

   task automatic test_fixed;
      clr(0); clr(1);
      for (int p = 0; p < 3; p++) req(0, p, 1'b0, 4'h0, 32'(p * 4), 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++;
         if (rdy[0] !== onehot(k)) begin n_err++; $display("FAIL fixed_grant k%0d: got %b want %b", k, rdy[0], onehot(k)); end
         tick;
         rv[0][k] = 1'b0;
         n_chk += 2;
         if (rspv[0] !== onehot(k)) begin n_err++; $display("FAIL fixed_rsp_valid k%0d: got %b want %b", k, rspv[0], onehot(k)); end
         if (rdat[0] !== mdl[0][k]) begin n_err++; $display("FAIL fixed_rdata k%0d: got %h want %h", k, rdat[0], mdl[0][k]); end
      end
   endtask

   task automatic test_rr;
      clr(0); clr(1);
      req(1, 0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick;
      clr(1);
      req(1, 2, 1'b0, 4'h0, 32'h8, 32'h0);
      #1;
      n_chk++;
      if (rdy[1] !== 3'b100) begin n_err++; $display("FAIL rr_alone_grant: got %b want 100", rdy[1]); end
      tick;
      clr(1);
      for (int m = 0; m < 2; m++)
         for (int p = 0; p < 3; p++) req(m, p, 1'b0, 4'h0, 32'(p * 4), 32'h0);
      for (int k = 0; k < 6; k++) begin
         #1;
         n_chk += 2;
         if (rdy[1] !== onehot(k % 3)) begin n_err++; $display("FAIL rr_grant k%0d: got %b want %b", k, rdy[1], onehot(k % 3)); end
         if (rdy[0] !== 3'b001) begin n_err++; $display("FAIL fixed_hold_grant k%0d: got %b want 001", k, rdy[0]); end
         tick;
         n_chk++;
         if (rspv[1] !== onehot(k % 3)) begin n_err++; $display("FAIL rr_rsp_valid k%0d: got %b want %b", k, rspv[1], onehot(k % 3)); end
      end
      clr(0); clr(1);
   endtask

   task automatic test_oor;
      logic [31:0] save [2];
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 0, 1'b0, 4'h0, 32'h8000, 32'h0); save[m] = mdl[m][0]; end
      tick;
      for (int m = 0; m < 2; m++) begin
         n_chk += 3;
         if (rspv[m] !== 3'b001) begin n_err++; $display("FAIL oor_rsp_valid m%0d: got %b want 001", m, rspv[m]); end
         if (rerr[m] !== 1'b1) begin n_err++; $display("FAIL oor_rsp_err m%0d: got %b want 1", m, rerr[m]); end
         if (rdat[m] !== 32'h0) begin n_err++; $display("FAIL oor_rdata m%0d: got %h want 0", m, rdat[m]); end
         clr(m);
         req(m, 0, 1'b1, 4'hF, 32'h8000, 32'hFFFFFFFF);
      end
      tick;
      for (int m = 0; m < 2; m++) begin
         n_chk += 2;
         if (werr[m] !== 1'b1) begin n_err++; $display("FAIL oor_wr_err m%0d: got %b want 1", m, werr[m]); end
         if (rerr[m] !== 1'b0) begin n_err++; $display("FAIL oor_err_idle m%0d: got %b want 0", m, rerr[m]); end
         clr(m);
         req(m, 0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      tick;
      for (int m = 0; m < 2; m++) begin
         clr(m);
         n_chk += 2;
         if (werr[m] !== 1'b0) begin n_err++; $display("FAIL oor_wr_err_pulse m%0d: got %b want 0", m, werr[m]); end
         if (rdat[m] !== save[m]) begin n_err++; $display("FAIL oor_ram0_kept m%0d: got %h want %h", m, rdat[m], save[m]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] old [2];
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 1, 1'b0, 4'h0, 32'h30, 32'h0); old[m] = mdl[m][12]; end
      tick;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 1, 1'b1, 4'hF, 32'h30, ~old[m]); end
      tick;
      for (int m = 0; m < 2; m++) begin
         n_chk += 2;
         if (rdat[m] !== old[m]) begin n_err++; $display("FAIL b2b_pending_rdata m%0d: got %h want %h", m, rdat[m], old[m]); end
         if (rspv[m] !== 3'b000) begin n_err++; $display("FAIL b2b_wr_no_rsp m%0d: got %b want 000", m, rspv[m]); end
         clr(m);
         req(m, 1, 1'b0, 4'h0, 32'h30, 32'h0);
      end
      tick;
      for (int m = 0; m < 2; m++) begin
         clr(m);
         n_chk++;
         if (rdat[m] !== ~old[m]) begin n_err++; $display("FAIL b2b_new_rdata m%0d: got %h want %h", m, rdat[m], ~old[m]); end
      end
   endtask

   task automatic test_random;
      int r;
      logic [31:0] a;
      clr(0); clr(1);
      for (int c = 0; c < 400; c++) begin
         for (int m = 0; m < 2; m++)
            for (int p = 0; p < 3; p++)
               if (!rv[m][p] && $urandom_range(0, 2) == 0) begin
                  r = int'($urandom_range(0, 9));
                  a = (r == 0) ? 32'h8000 + $urandom_range(0, 255) : (r == 1) ? 32'hFFFFFFFC : 32'($urandom_range(0, 255));
                  req(m, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
               end
         #1;
         for (int m = 0; m < 2; m++) begin
            n_chk += 5;
            if (rdy[m] !== onehot(winner(m))) begin n_err++; $display("FAIL rand_grant m%0d c%0d: got %b want %b", m, c, rdy[m], onehot(winner(m))); end
            if (rspv[m] !== e_v[m]) begin n_err++; $display("FAIL rand_rsp_valid m%0d c%0d: got %b want %b", m, c, rspv[m], e_v[m]); end
            if (rerr[m] !== e_err[m]) begin n_err++; $display("FAIL rand_rsp_err m%0d c%0d: got %b want %b", m, c, rerr[m], e_err[m]); end
            if (werr[m] !== e_werr[m]) begin n_err++; $display("FAIL rand_wr_err m%0d c%0d: got %b want %b", m, c, werr[m], e_werr[m]); end
            if (rdat[m] !== e_dat[m]) begin n_err++; $display("FAIL rand_rdata m%0d c%0d: got %h want %h", m, c, rdat[m], e_dat[m]); end
         end
         tick;
         for (int m = 0; m < 2; m++) if (gw[m] >= 0) rv[m][gw[m]] = 1'b0;
      end
      clr(0); clr(1);
      tick;
   endtask

   task automatic test_reset_mid;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 1, 1'b0, 4'h0, 32'h10, 32'h0); end
      tick;
      for (int m = 0; m < 2; m++) begin clr(m); req(m, 0, 1'b0, 4'h0, 32'h10, 32'h0); end
      #1;
      rstn = 1'b0;
      model_reset;
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         n_chk += 2;
         if (rspv[m] !== 3'b000) begin n_err++; $display("FAIL rstmid_rsp_valid m%0d: got %b want 000", m, rspv[m]); end
         if (rdat[m] !== 32'h0) begin n_err++; $display("FAIL rstmid_rdata m%0d: got %h want 0", m, rdat[m]); end
      end
      #1;
      rstn = 1'b1;
      for (int m = 0; m < 2; m++) begin
         clr(m);
         for (int p = 0; p < 3; p++) req(m, p, 1'b0, 4'h0, 32'(p * 4), 32'h0);
      end
      #1;
      for (int m = 0; m < 2; m++) begin
         n_chk++;
         if (rdy[m] !== 3'b001) begin n_err++; $display("FAIL rstmid_first_grant m%0d: got %b want 001", m, rdy[m]); end
      end
      tick;
      for (int m = 0; m < 2; m++) begin
         n_chk += 2;
         if (rspv[m] !== 3'b001) begin n_err++; $display("FAIL rstmid_rsp m%0d: got %b want 001", m, rspv[m]); end
         if (rdat[m] !== mdl[m][0]) begin n_err++; $display("FAIL rstmid_rdata2 m%0d: got %h want %h", m, rdat[m], mdl[m][0]); end
         clr(m);
      end
   endtask

   initial begin
      clr(0); clr(1);
      model_reset;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      rstn = 1'b1;
      init_mem;
      test_basic;
      test_strobes;
      test_fixed;
      test_rr;
      test_oor;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dtcm_mp_arb.md
Name: dtcm_mp_arb

Overview:
Parametrised, single-port-RAM data TCM shared by NUM_PORTS requestors, e.g. port 0 = DMA, port 1 = core data, port 2 = core instruction.
- A per-cycle arbiter grants one request, selectable as fixed-priority or round-robin.
- Writes use per-port byte strobes.
- Reads return one cycle after grant, with a one-hot response valid and an out-of-range error flag.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8, power of two)
ADDR_WIDTH, 32, byte address width
DEPTH, 8192, memory depth in words (power of two)
NUM_PORTS, 3, number of requestor ports (2..8)
ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin

Ports:
clk  in  1  clock
rstn  in  1  asynchronous reset, active low
req_valid  in  NUM_PORTS  per-port access request
req_ready  out  NUM_PORTS  per-port grant, combinational, one-hot or zero
req_wr  in  NUM_PORTS  per-port command, rd=0 wr=1
req_strb  in  NUM_PORTS*DATA_WIDTH/8  per-port byte strobes, port p at [p*SB +: SB]
req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port byte address
req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
rsp_valid  out  NUM_PORTS  one-hot read-data valid, one cycle after read grant
rsp_err  out  1  qualifies rsp_valid: read address was out of range
rsp_rdata  out  DATA_WIDTH  shared read data
wr_err  out  1  pulse, one cycle after a granted out-of-range write

Behaviour:
- Transfer: a transfer occurs on port p when req_valid[p] && req_ready[p] at a clk edge. A requestor holds valid, wr, strb, addr and wdata stable until the grant; no retraction is required.
- Grant count: at most one grant per cycle. req_ready[p] = 1 only for the arbiter winner; no valid requests gives all-zero grant.
- ARB_MODE=0: the lowest-index valid port wins.
- ARB_MODE=1:
  - Priority pointer ptr starts at port 0 after reset.
  - The winner is the first valid port at or after ptr, wrapping modulo NUM_PORTS.
  - After any grant, ptr = winner+1 mod NUM_PORTS; with no grant, ptr holds.
  - Guarantees each continuously requesting port is granted within NUM_PORTS cycles.
- Address decode:
  - widx = req_addr >> log2(DATA_WIDTH/8).
  - In range iff widx < DEPTH; the RAM index is widx[log2(DEPTH)-1:0].
  - Low byte-offset bits are ignored.
- Write grant:
  - In range: each byte lane b with strb[b]=1 is updated at the grant edge; strb=0 performs no write but is still a transfer.
  - Out of range: the RAM is not modified; wr_err = 1 for exactly the next cycle.
- Read grant:
  - The next cycle has rsp_valid[p]=1 and rsp_rdata = RAM content as of the grant edge.
  - Reads use read-before-write ordering (irrelevant with a single port, since reads and writes cannot occur in the same cycle).
  - Out of range: rsp_rdata = 0, rsp_err = 1.
- Output hold: rsp_rdata holds its last value when rsp_valid = 0. rsp_err is 0 whenever rsp_valid = 0.
- Back-to-back traffic: reads on consecutive cycles give a response every cycle, full throughput. A write granted directly after a read to the same address does not disturb the pending response.
- Reset values: rsp_valid=0, rsp_err=0, wr_err=0, rsp_rdata=0, ptr=0. req_ready is combinational and therefore 0 while all req_valid=0.
- RAM contents are not reset.
- Reset asserted mid-operation clears any pending response; the read whose grant coincided with reset assertion produces no rsp_valid.
- Elaboration-time check: DATA_WIDTH%8 != 0, non-power-of-two DEPTH, or NUM_PORTS outside 2..8 is an error.

Test Plan:
1. Basic access: port 1 writes 0xDEADBEEF to 0x0000_0010 with strb=0xF, then reads it -> next-cycle rsp_valid=3'b010, rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte strobes: write 0x11223344 with strb=0xF, then write 0xAABBCCDD with strb=0x5 to the same address, then read -> rsp_rdata=0x11BB33DD.
3. Fixed priority (ARB_MODE=0): ports 0, 1 and 2 request reads in the same cycle, held -> grants 0, 1, 2 in successive cycles; rsp_valid sequence 001, 010, 100.
4. Round-robin (ARB_MODE=1): all three ports request continuously for 6 cycles -> grant order 0,1,2,0,1,2. Port 2 alone after a port 0 grant -> granted immediately.
5. Out of range (DEPTH=8192): read at addr 0x0000_8000 -> rsp_valid set, rsp_err=1, rsp_rdata=0. Write to the same address -> wr_err pulses for 1 cycle and RAM index 0 is unchanged.
6. Reset mid-operation: assert rstn low in the cycle a read is granted -> rsp_valid stays 0, rsp_rdata=0. After release, the first grant goes to port 0 in both modes.
